// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - shared types and constants for the ADC SPI responder.
// Define ADC_RESP_PARITY_EN to append an even-parity bit after the sample LSB.
package adc_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      TAIL
   } state_e;

   localparam int ADC_DATA_WIDTH_DEF = 16;
   localparam int SYNC_STAGES        = 2;

`ifdef ADC_RESP_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/adc_spi_responder_sync_edge_det.sv
// rtl/adc_spi_responder_sync_edge_det.sv - 2-FF synchronizer with registered rise/fall pulses.
// A pin edge shows up as a one-cycle pulse three clk edges later.
module sync_edge_det
   import adc_spi_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic din_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lvl_q;
   logic                   rise_q;
   logic                   fall_q;

   // Reset to 0 on both lines: a rise seen in IDLE is harmless, a spurious fall is not.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         lvl_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
         lvl_q  <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & lvl_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI slave that emulates a serial ADC, sample shifted out MSB first.
// Optional ADC_RESP_PARITY_EN appends an even-parity bit to each frame.
module adc_spi_responder
   import adc_spi_pkg::*;
#(
   parameter int   DATA_WIDTH = ADC_DATA_WIDTH_DEF,
   parameter int   LEAD_BITS  = 0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] sample_data,
   input  logic                  sample_valid,
   input  logic                  clk_spi,
   input  logic                  cs_spi,
   output logic                  sd_spi,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_abort
);

   localparam int FRAME_BITS = LEAD_BITS + DATA_WIDTH + PARITY_BITS;
   localparam int CW         = $clog2(FRAME_BITS + 1);

   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_WIDTH-1:0] s);
      logic [FRAME_BITS-1:0] f;
      f = '0;
      f[PARITY_BITS +: DATA_WIDTH] = s;
`ifdef ADC_RESP_PARITY_EN
      f[0] = ^s;
`endif
      return f;
   endfunction

   logic clk_rise, clk_fall, cs_rise, cs_fall;

   sync_edge_det u_clk_sync (
      .clk    (clk),
      .rstn   (rstn),
      .din_i  (clk_spi),
      .rise_o (clk_rise),
      .fall_o (clk_fall)
   );

   sync_edge_det u_cs_sync (
      .clk    (clk),
      .rstn   (rstn),
      .din_i  (cs_spi),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   state_e                state_q;
   logic [DATA_WIDTH-1:0] hold_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         rise_cnt_q;
   logic                  sd_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  abort_q;
   logic [FRAME_BITS-1:0] frame_d;

   // A sample arriving in the same cycle as the cs fall bypasses the holding register.
   assign frame_d = build_frame(sample_valid ? sample_data : hold_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         shift_q    <= '0;
         cnt_q      <= '0;
         rise_cnt_q <= '0;
         sd_q       <= IDLE_LEVEL;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         if (sample_valid) hold_q <= sample_data;
         case (state_q)
            IDLE: begin
               sd_q   <= IDLE_LEVEL;
               busy_q <= 1'b0;
               if (cs_fall) begin
                  shift_q    <= frame_d << 1;
                  sd_q       <= frame_d[FRAME_BITS-1];
                  cnt_q      <= CW'(1);
                  rise_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  if (rise_cnt_q < CW'(FRAME_BITS)) abort_q <= 1'b1;
                  else                              done_q  <= 1'b1;
                  sd_q    <= IDLE_LEVEL;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  if (clk_fall) begin
                     if (cnt_q == CW'(FRAME_BITS)) begin
                        sd_q    <= 1'b0;
                        state_q <= TAIL;
                     end else begin
                        sd_q    <= shift_q[FRAME_BITS-1];
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q + CW'(1);
                     end
                  end
                  if (clk_rise && rise_cnt_q != CW'(FRAME_BITS))
                     rise_cnt_q <= rise_cnt_q + CW'(1);
               end
            end
            TAIL: begin
               if (cs_rise) begin
                  done_q  <= 1'b1;
                  sd_q    <= IDLE_LEVEL;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  sd_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sd_spi      = sd_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_abort = abort_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - randomized self-checking bench for adc_spi_responder.
module tb_adc_spi_responder;

   localparam int DW = 16;
   localparam int H  = 10;
`ifdef ADC_RESP_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FB0 = DW + PB;
   localparam int FB1 = 2 + DW + PB;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] sample_data = '0;
   logic          sample_valid = 1'b0;
   logic          clk_spi = 1'b0;
   logic          cs_spi = 1'b1;
   logic          sd0, busy0, done0, abort0;
   logic          sd1, busy1, done1, abort1;

   always #5 clk = ~clk;

   adc_spi_responder #(.DATA_WIDTH(DW), .LEAD_BITS(0), .IDLE_LEVEL(1'b0)) u_dut0 (
      .clk(clk), .rstn(rstn), .sample_data(sample_data), .sample_valid(sample_valid),
      .clk_spi(clk_spi), .cs_spi(cs_spi), .sd_spi(sd0), .busy(busy0),
      .frame_done(done0), .frame_abort(abort0));

   adc_spi_responder #(.DATA_WIDTH(DW), .LEAD_BITS(2), .IDLE_LEVEL(1'b1)) u_dut1 (
      .clk(clk), .rstn(rstn), .sample_data(sample_data), .sample_valid(sample_valid),
      .clk_spi(clk_spi), .cs_spi(cs_spi), .sd_spi(sd1), .busy(busy1),
      .frame_done(done1), .frame_abort(abort1));

   int checks = 0;
   int failures = 0;
   int done_n0 = 0, done_n1 = 0, abort_n0 = 0, abort_n1 = 0;
   logic [DW-1:0] cur;

   always @(posedge clk) begin
      if (done0)  done_n0  <= done_n0 + 1;
      if (done1)  done_n1  <= done_n1 + 1;
      if (abort0) abort_n0 <= abort_n0 + 1;
      if (abort1) abort_n1 <= abort_n1 + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bit i of the serial stream the master sees: lead zeros, sample MSB first, parity, then zeros.
   function automatic logic exp_bit(input int lead, input logic [DW-1:0] s, input int i);
      if (i < lead) return 1'b0;
      if (i < lead + DW) return s[DW-1-(i-lead)];
      if (PB == 1 && i == lead + DW) return ^s;
      return 1'b0;
   endfunction

   function automatic logic [63:0] exp_read(input int lead, input logic [DW-1:0] s, input int n);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r = {r[62:0], exp_bit(lead, s, i)};
      return r;
   endfunction

   task automatic load(input logic [DW-1:0] v);
      @(negedge clk);
      sample_data  = v;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      cur = v;
   endtask

   task automatic frame(input string tag, input int n, input int rst_at,
                        input logic inj, input logic [DW-1:0] inj_data);
      int          d0, d1, a0, a1;
      logic [63:0] r0, r1;
      logic [DW-1:0] s;
      bit          lost;
      d0 = done_n0; d1 = done_n1; a0 = abort_n0; a1 = abort_n1;
      r0 = '0; r1 = '0; lost = 1'b0;
      @(negedge clk);
      cs_spi = 1'b0;
      if (inj) begin
         repeat (3) @(posedge clk);
         @(negedge clk);
         sample_data  = inj_data;
         sample_valid = 1'b1;
         @(negedge clk);
         sample_valid = 1'b0;
         cur = inj_data;
      end
      s = cur;
      repeat (H) @(negedge clk);
      check({tag, " busy_in_frame"}, {62'd0, busy1, busy0}, 64'd3);
      for (int i = 0; i < n; i++) begin
         r0 = {r0[62:0], sd0};
         r1 = {r1[62:0], sd1};
         clk_spi = 1'b1;
         repeat (H) @(negedge clk);
         if (i + 1 == rst_at) begin
            rstn = 1'b0;
            @(negedge clk);
            check({tag, " sd_in_reset"}, {62'd0, sd1, sd0}, 64'd2);
            check({tag, " busy_in_reset"}, {62'd0, busy1, busy0}, 64'd0);
            rstn = 1'b1;
            lost = 1'b1;
            cur = '0;
         end
         clk_spi = 1'b0;
         repeat (H) @(negedge clk);
      end
      cs_spi = 1'b1;
      repeat (H) @(negedge clk);
      check({tag, " busy_after"}, {62'd0, busy1, busy0}, 64'd0);
      check({tag, " sd_idle"}, {62'd0, sd1, sd0}, 64'd2);
      if (!lost) begin
         check({tag, " read0"}, r0, exp_read(0, s, n));
         check({tag, " read1"}, r1, exp_read(2, s, n));
      end
      check({tag, " done0"},  64'(done_n0 - d0),  64'((!lost && n >= FB0) ? 1 : 0));
      check({tag, " abort0"}, 64'(abort_n0 - a0), 64'((!lost && n <  FB0) ? 1 : 0));
      check({tag, " done1"},  64'(done_n1 - d1),  64'((!lost && n >= FB1) ? 1 : 0));
      check({tag, " abort1"}, 64'(abort_n1 - a1), 64'((!lost && n <  FB1) ? 1 : 0));
   endtask

   initial begin
      logic [DW-1:0] v;
      int            n;
      logic          inj;
      cur = '0;
      repeat (3) @(negedge clk);
      check("rst_sd",    {62'd0, sd1, sd0}, 64'd2);
      check("rst_busy",  {62'd0, busy1, busy0}, 64'd0);
      check("rst_pulse", {60'd0, done1, done0, abort1, abort0}, 64'd0);
      rstn = 1'b1;
      repeat (5) @(negedge clk);

      load(16'hA5C3);
      frame("basic", 16, -1, 1'b0, '0);

      load(16'h1234);
      frame("same_cycle", 16, -1, 1'b1, 16'hBEEF);

      load(16'h00FF);
      frame("abort7", 7, -1, 1'b0, '0);
      frame("after_abort", 16, -1, 1'b0, '0);

      load(16'hFFFF);
      frame("lead20", 20, -1, 1'b0, '0);

      load(16'h5A5A);
      frame("mid_reset", 10, 5, 1'b0, '0);
      load(16'h3C96);
      frame("post_reset", 20, -1, 1'b0, '0);

      load(16'h0007);
      frame("parity", 17, -1, 1'b0, '0);

      for (int k = 0; k < 10; k++) begin
         v   = DW'($urandom);
         n   = $urandom_range(5, 24);
         inj = 1'($urandom_range(0, 1));
         load(v);
         frame($sformatf("rand%0d", k), n, -1, inj, DW'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
Synthesizable SPI responder that emulates a serial ADC on the slave side of the adc SPI link (clk_spi, cs_spi, sd_spi). A parallel sample is latched on chip-select assertion and shifted out MSB first on the serial data line. Used for hardware-in-the-loop loopback of the adc reader and as a stand-in converter on boards without the real part. All logic runs on the fabric clock; clk_spi and cs_spi are oversampled, not used as clocks.

Parameters:
DATA_WIDTH, 16, bits per sample shifted out.
LEAD_BITS, 0, zero bits driven before the sample MSB; range 0..7.
IDLE_LEVEL, 1'b0, sd_spi level while cs_spi is high.

Ports:
clk  in  1  fabric clock; sole clock domain.
rstn  in  1  asynchronous active-low reset.
sample_data  in  DATA_WIDTH  parallel sample to transmit.
sample_valid  in  1  loads sample_data into the holding register.
clk_spi  in  1  SPI clock from the master; idles low; asynchronous to clk.
cs_spi  in  1  active-low chip select from the master; asynchronous to clk.
sd_spi  out  1  serial data to the master.
busy  out  1  high while a frame is active.
frame_done  out  1  one-cycle pulse when a complete frame ends.
frame_abort  out  1  one-cycle pulse when cs_spi rises before the last bit.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; sd_spi=IDLE_LEVEL; busy=0; frame_done=0; frame_abort=0; holding register=0; bit counter=0.
- Inputs: 2-FF synchronizer on clk_spi and cs_spi, followed by a registered edge detector. The internal event fires 3 clk cycles after the pin edge.
- Master constraint: clk_spi half-period >= 4 clk cycles. Faster operation is undefined.
- Holding register: loads when sample_valid=1. If sample_valid is high in the same cycle as the cs fall event, the new sample_data is sent.
- FRAME_BITS = LEAD_BITS + DATA_WIDTH (+1 if parity is enabled).
- State IDLE:
  - sd_spi=IDLE_LEVEL.
  - On cs fall: load shift register = {LEAD_BITS zeros, holding}; drive bit 0 of the frame on sd_spi the same cycle as the event; counter=1; busy=1; go to SHIFT.
- State SHIFT:
  - Each clk_spi fall event drives the next frame bit and increments the counter. The master samples on clk_spi rise.
  - When the counter reaches FRAME_BITS, the next fall event drives 0 and the state moves to TAIL.
  - clk_spi rise events only matter for abort tracking.
- State TAIL: sd_spi=0 for any extra clocks.
- cs rise in SHIFT:
  - If fewer than FRAME_BITS rise events were seen, pulse frame_abort; otherwise pulse frame_done.
  - Then go to IDLE with busy=0 and sd_spi=IDLE_LEVEL.
- cs rise in TAIL: pulse frame_done; go to IDLE.
- Simultaneous events: a cs rise in the same cycle as a clk_spi event takes priority; the clock event is ignored.
- clk_spi edges while cs_spi is high are ignored.
- rstn asserted mid-frame: immediate return to the reset state. No pulse is generated, and the frame is lost.
- Rise counter: counts clk_spi rise events in a frame and saturates at FRAME_BITS.

Optional Feature:
ADC_RESP_PARITY_EN
- Defined: one even-parity bit (XOR of the sample bits) is appended after the LSB, and FRAME_BITS increases by 1.
- Undefined: no parity bit; the frame is exactly LEAD_BITS + DATA_WIDTH bits.

Decomposition:
- Package adc_spi_pkg holds:
  - state enum {IDLE, SHIFT, TAIL};
  - ADC_DATA_WIDTH_DEF=16;
  - synchronizer depth constant SYNC_STAGES=2.
- Sub-module sync_edge_det: 2-FF synchronizer plus rise/fall pulse outputs. Instantiated for clk_spi and for cs_spi.

Test Plan:
- Load sample_data=16'hA5C3, then run a 16-clock master frame with clk_div=10 -> master reads 16'hA5C3; frame_done pulses once; busy high from the cs fall event until the cs rise event.
- Set sample_valid in the same cycle as the cs fall event, with the old value 16'h1234 and new value 16'hBEEF -> 16'hBEEF is shifted out.
- Raise cs_spi after 7 clk_spi rises, then send a normal frame with 16'h00FF -> frame_abort pulses once with no frame_done; the next frame reads 16'h00FF.
- LEAD_BITS=2 with sample 16'hFFFF and 20 master clocks -> bits read are 00, then sixteen 1s, then 00; frame_done pulses.
- Assert rstn mid-frame after bit 5 -> sd_spi=IDLE_LEVEL, busy=0, no pulses; the next full frame is correct.
- ADC_RESP_PARITY_EN defined, sample 16'h0007, 17 master clocks -> 17th bit =1.
